// File: rtl/adder_pipe_nbit.sv
// Pipelined WIDTH-bit adder/subtractor, one STAGE_BITS-wide carry slice per register stage.
// Define ADDER_PIPE_SAT_EN to saturate the result to the signed extreme on overflow.
module adder_pipe_nbit #(
    parameter int WIDTH      = 16,
    parameter int STAGE_BITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             overflow
);
    localparam int STAGES = WIDTH / STAGE_BITS;

    logic advance;
    logic accept;

    // Operands shift right as slices are consumed; finished sum slices enter at the top,
    // so after the last stage sum_reg holds the result in natural bit order.
    logic             valid_reg [STAGES];
    logic [WIDTH-1:0] a_reg     [STAGES];
    logic [WIDTH-1:0] b_reg     [STAGES];
    logic [WIDTH-1:0] sum_reg   [STAGES];
    logic             carry_reg [STAGES];
    logic             ovf_reg;

    logic             v_in      [STAGES];
    logic [WIDTH-1:0] a_nxt     [STAGES];
    logic [WIDTH-1:0] b_nxt     [STAGES];
    logic [WIDTH-1:0] sum_nxt   [STAGES];
    logic             carry_nxt [STAGES];
    logic             ovf_nxt;
`ifdef ADDER_PIPE_SAT_EN
    logic             sign_nxt;
    logic             sign_reg;
`endif

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance & ~rst;
    assign accept   = in_valid & in_ready;

    for (genvar gi = 0; gi < STAGES; gi++) begin : gen_stage
        logic [WIDTH-1:0]    a_src;
        logic [WIDTH-1:0]    b_src;
        logic [WIDTH-1:0]    sum_src;
        logic                c_src;
        logic [STAGE_BITS:0] slice_sum;

        if (gi == 0) begin : gen_first
            assign a_src   = in_a;
            assign b_src   = in_b ^ {WIDTH{sub}};
            assign c_src   = carry_in ^ sub;
            assign sum_src = '0;
            assign v_in[gi] = accept;
        end else begin : gen_next
            assign a_src   = a_reg[gi-1];
            assign b_src   = b_reg[gi-1];
            assign c_src   = carry_reg[gi-1];
            assign sum_src = sum_reg[gi-1];
            assign v_in[gi] = valid_reg[gi-1];
        end

        assign slice_sum = {1'b0, a_src[STAGE_BITS-1:0]} + {1'b0, b_src[STAGE_BITS-1:0]}
                         + {{STAGE_BITS{1'b0}}, c_src};

        assign a_nxt[gi]     = a_src >> STAGE_BITS;
        assign b_nxt[gi]     = b_src >> STAGE_BITS;
        assign sum_nxt[gi]   = (sum_src >> STAGE_BITS)
                             | (WIDTH'(slice_sum[STAGE_BITS-1:0]) << (WIDTH - STAGE_BITS));
        assign carry_nxt[gi] = slice_sum[STAGE_BITS];

        if (gi == STAGES - 1) begin : gen_last
            // Carry into the MSB is a^b^s at that bit; overflow is it XOR carry out.
            assign ovf_nxt = a_src[STAGE_BITS-1] ^ b_src[STAGE_BITS-1]
                           ^ slice_sum[STAGE_BITS-1] ^ slice_sum[STAGE_BITS];
`ifdef ADDER_PIPE_SAT_EN
            assign sign_nxt = a_src[STAGE_BITS-1];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_reg[k] <= 1'b0;
                a_reg[k]     <= '0;
                b_reg[k]     <= '0;
                sum_reg[k]   <= '0;
                carry_reg[k] <= 1'b0;
            end
            ovf_reg <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_reg[k] <= v_in[k];
                if (v_in[k]) begin
                    a_reg[k]     <= a_nxt[k];
                    b_reg[k]     <= b_nxt[k];
                    sum_reg[k]   <= sum_nxt[k];
                    carry_reg[k] <= carry_nxt[k];
                end
            end
            if (v_in[STAGES-1]) begin
                ovf_reg <= ovf_nxt;
            end
        end
    end

    assign out_valid = valid_reg[STAGES-1];
    assign carry_out = carry_reg[STAGES-1];
    assign overflow  = ovf_reg;

`ifdef ADDER_PIPE_SAT_EN
    localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(1) << (WIDTH - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_reg <= 1'b0;
        end else if (advance && v_in[STAGES-1]) begin
            sign_reg <= sign_nxt;
        end
    end

    assign out = ovf_reg ? (sign_reg ? MIN_NEG : ~MIN_NEG) : sum_reg[STAGES-1];
`else
    assign out = sum_reg[STAGES-1];
`endif

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Scoreboard bench for adder_pipe_nbit: driver pushes model results, negedge monitor pops and checks.
// Honours ADDER_PIPE_SAT_EN in the reference model.
module tb_adder_pipe_nbit;
    localparam int W   = 16;
    localparam int SB  = 4;
    localparam int STG = W / SB;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         carry_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out;
    logic         carry_out;
    logic         overflow;

    always #5 clk = ~clk;

    adder_pipe_nbit #(.WIDTH(W), .STAGE_BITS(SB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .carry_in  (carry_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic         s;
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
        int           acc_cyc;
        int           acc_stall;
    } exp_t;

    exp_t sb_q[$];
    int   checks     = 0;
    int   errors     = 0;
    int   cyc        = 0;
    int   stall_cnt  = 0;
    int   n_out      = 0;
    logic rand_ready = 1'b0;
    logic ready_force = 1'b1;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: integer arithmetic on unsigned and signed interpretations.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic s);
        exp_t         e;
        logic [W-1:0] be;
        longint       ua, ube, usum, sa, sbe, ssum, smax, smin, c;
        be   = s ? ~b : b;
        c    = longint'(ci ^ s);
        ua   = longint'(a);
        ube  = longint'(be);
        usum = ua + ube + c;
        sa   = a[W-1]  ? ua  - (longint'(1) << W) : ua;
        sbe  = be[W-1] ? ube - (longint'(1) << W) : ube;
        ssum = sa + sbe + c;
        smax = (longint'(1) << (W - 1)) - 1;
        smin = -(longint'(1) << (W - 1));
        e.a = a; e.b = b; e.ci = ci; e.s = s;
        e.res  = usum[W-1:0];
        e.cout = (usum >= (longint'(1) << W));
        e.ovf  = (ssum > smax) || (ssum < smin);
`ifdef ADDER_PIPE_SAT_EN
        if (ssum > smax) e.res = smax[W-1:0];
        if (ssum < smin) e.res = smin[W-1:0];
`endif
        e.acc_cyc   = 0;
        e.acc_stall = 0;
        return e;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #2;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end

    // Monitor
    initial begin
        exp_t         e;
        logic         hold_prev;
        logic [W-1:0] prev_out;
        logic         prev_c, prev_o;
        hold_prev = 1'b0;
        prev_out = '0; prev_c = 1'b0; prev_o = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev && out_valid) begin
                    chk("stall_out_stable", out, prev_out);
                    chk("stall_cout_stable", carry_out, prev_c);
                    chk("stall_ovf_stable", overflow, prev_o);
                end
                if (out_valid && !out_ready) begin
                    chk("stall_in_ready", in_ready, 0);
                    hold_prev = 1'b1;
                    prev_out = out; prev_c = carry_out; prev_o = overflow;
                    stall_cnt++;
                end else begin
                    hold_prev = 1'b0;
                end
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out actual=0x%0h required=no_output (cycle %0d)", out, cyc);
                    end else begin
                        e = sb_q.pop_front();
                        chk("out", out, e.res);
                        chk("carry_out", carry_out, e.cout);
                        chk("overflow", overflow, e.ovf);
                        chk("latency", cyc - e.acc_cyc, STG + stall_cnt - e.acc_stall);
                        $display("txn %0d: a=%h b=%h cin=%b sub=%b -> out=%h cout=%b ovf=%b lat=%0d",
                                 n_out, e.a, e.b, e.ci, e.s, out, carry_out, overflow, cyc - e.acc_cyc);
                        n_out++;
                    end
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic s);
        exp_t e;
        bit   done;
        done = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1; in_a = a; in_b = b; carry_in = ci; sub = s;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                e = model(a, b, ci, s);
                e.acc_cyc   = cyc;
                e.acc_stall = stall_cnt;
                sb_q.push_back(e);
                done = 1'b1;
            end
        end
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && sb_q.size() != 0; t++) @(negedge clk);
        chk("drain_empty", sb_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return {1'b0, {(W-1){1'b1}}};
            3: return {1'b1, {(W-1){1'b0}}};
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h4321; carry_in = 1'b0; sub = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out", out, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_carry", carry_out, 0);
            chk("rst_ovf", overflow, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1);
        repeat (6) @(negedge clk);

        // Directed add, subtract and overflow cases
        send(16'h00FF, 16'h0001, 1'b0, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        send(16'h0005, 16'h0007, 1'b0, 1'b1);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        send(16'h0009, 16'h0003, 1'b1, 1'b1);
        send(16'h1000, 16'h0FFF, 1'b1, 1'b0);
        idle();
        drain();

        // Streaming: back-to-back random pairs
        for (int i = 0; i < 8; i++) send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        idle();
        drain();

        // Backpressure: fill while downstream stalls, hold 3 cycles, release
        @(posedge clk);
        #1;
        ready_force = 1'b0;
        for (int i = 0; i < 4; i++) send(pick(), pick(), 1'($urandom), 1'($urandom));
        idle();
        repeat (3) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        ready_force = 1'b1;
        drain();

        // Random traffic with random downstream readiness
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            send(pick(), pick(), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) idle();
        end
        idle();
        rand_ready = 1'b0;
        drain();

        // Reset mid-flight discards in-flight work
        for (int i = 0; i < 3; i++) send(pick(), pick(), 1'($urandom), 1'($urandom));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        send(16'h1234, 16'h0FF1, 1'b0, 1'b1);
        idle();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
